// File: rtl/sdrc_pkg.sv
// sdrc_pkg: shared types and constants for the r2b/b2r request path.
package sdrc_pkg;

  localparam int SDR_REQ_ID_W = 4;
  localparam int REQ_BW       = 12;
  localparam int BANKS        = 4;

  typedef enum logic {
    EXP_START,
    EXP_CONT
  } frame_e;

  typedef struct packed {
    logic [SDR_REQ_ID_W-1:0] req_id;
    logic                    start;
    logic                    last;
    logic                    wrap;
    logic                    write;
    logic [1:0]              ba;
    logic [12:0]             raddr;
    logic [12:0]             caddr;
    logic [REQ_BW-1:0]       len;
  } r2b_entry_t;

endpackage

// File: rtl/sdrc_req_rcv_if.sv
// sdrc_req_rcv_if: r2b request channel plus queued-chunk output channel.
interface sdrc_req_rcv_if #(
  parameter int ID_W  = 4,
  parameter int LEN_W = 12
);
  logic             r2b_req;
  logic [ID_W-1:0]  r2b_req_id;
  logic             r2b_start;
  logic             r2b_last;
  logic             r2b_wrap;
  logic             r2b_write;
  logic [1:0]       r2b_ba;
  logic [12:0]      r2b_raddr;
  logic [12:0]      r2b_caddr;
  logic [LEN_W-1:0] r2b_len;
  logic             b2r_ack;
  logic             b2r_arb_ok;

  logic             q_valid;
  logic             q_ready;
  logic [ID_W-1:0]  q_req_id;
  logic             q_start;
  logic             q_last;
  logic             q_wrap;
  logic             q_write;
  logic [1:0]       q_ba;
  logic [12:0]      q_raddr;
  logic [12:0]      q_caddr;
  logic [LEN_W-1:0] q_len;
  logic             q_row_hit;

  modport slave (
    input  r2b_req, r2b_req_id, r2b_start, r2b_last,
    input  r2b_wrap, r2b_write, r2b_ba, r2b_raddr,
    input  r2b_caddr, r2b_len, q_ready,
    output b2r_ack, b2r_arb_ok, q_valid,
    output q_req_id, q_start, q_last, q_wrap,
    output q_write, q_ba, q_raddr, q_caddr,
    output q_len, q_row_hit
  );

  modport master (
    output r2b_req, r2b_req_id, r2b_start, r2b_last,
    output r2b_wrap, r2b_write, r2b_ba, r2b_raddr,
    output r2b_caddr, r2b_len, q_ready,
    input  b2r_ack, b2r_arb_ok, q_valid,
    input  q_req_id, q_start, q_last, q_wrap,
    input  q_write, q_ba, q_raddr, q_caddr,
    input  q_len, q_row_hit
  );
endinterface

// File: rtl/sdrc_row_tracker.sv
// sdrc_row_tracker: per-bank open-row table for head-of-queue row-hit hint.
module sdrc_row_tracker
  import sdrc_pkg::*;
(
  input  logic             clk,
  input  logic             reset_n,
  input  logic             pop,
  input  logic             q_valid,
  input  logic [1:0]       ba,
  input  logic [12:0]      raddr,
  input  logic [BANKS-1:0] row_close,
  output logic             row_hit
);
  logic [12:0]      row [BANKS];
  logic [BANKS-1:0] vld;

  // A precharge wins over a same-cycle activate of that bank.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      vld <= '0;
    end else begin
      for (int b = 0; b < BANKS; b++) begin
        if (row_close[b])
          vld[b] <= 1'b0;
        else if (pop && ba == 2'(b))
          vld[b] <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (pop)
      row[ba] <= raddr;
  end

  assign row_hit = q_valid & vld[ba] & (row[ba] == raddr);
endmodule

// File: rtl/sdrc_req_rcv.sv
// sdrc_req_rcv: r2b chunk FIFO with arb_ok headroom and framing check.
// Define SDRC_ROW_HIT_EN to build the open-row hit tracker.
module sdrc_req_rcv
  import sdrc_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int ID_W  = SDR_REQ_ID_W,
  parameter int LEN_W = REQ_BW
) (
  input  logic                   clk,
  input  logic                   reset_n,
  sdrc_req_rcv_if.slave          bus,
  input  logic [BANKS-1:0]       row_close,
  output logic                   proto_err,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int EW = ID_W + 2 + 13 + 13 + LEN_W + 4;

  logic [EW-1:0] mem [DEPTH];
  logic [EW-1:0] din;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          push;
  logic          pop;
  frame_e        frame;

  // Push is gated by the registered count, so a pop never frees a slot early.
  assign push           = bus.r2b_req & (count < CW'(DEPTH));
  assign bus.b2r_ack    = push;
  assign bus.q_valid    = count != '0;
  assign pop            = bus.q_valid & bus.q_ready;
  assign bus.b2r_arb_ok = count <= CW'(DEPTH - 2);

  assign din = {bus.r2b_req_id, bus.r2b_start, bus.r2b_last,
                bus.r2b_wrap, bus.r2b_write, bus.r2b_ba,
                bus.r2b_raddr, bus.r2b_caddr, bus.r2b_len};

  assign {bus.q_req_id, bus.q_start, bus.q_last,
          bus.q_wrap, bus.q_write, bus.q_ba,
          bus.q_raddr, bus.q_caddr, bus.q_len} = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + AW'(1);
      if (pop)
        rd_ptr <= rd_ptr + AW'(1);
      unique case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      frame     <= EXP_START;
      proto_err <= 1'b0;
    end else if (push) begin
      if ((frame == EXP_START) != bus.r2b_start)
        proto_err <= 1'b1;
      frame <= bus.r2b_last ? EXP_START : EXP_CONT;
    end
  end

`ifdef SDRC_ROW_HIT_EN
  sdrc_row_tracker u_row_tracker (
    .clk       (clk),
    .reset_n   (reset_n),
    .pop       (pop),
    .q_valid   (bus.q_valid),
    .ba        (bus.q_ba),
    .raddr     (bus.q_raddr),
    .row_close (row_close),
    .row_hit   (bus.q_row_hit)
  );
`else
  logic unused_row_close;
  assign unused_row_close = ^row_close;
  assign bus.q_row_hit    = 1'b0;
`endif
endmodule

// File: doc/sdrc_req_rcv.md
Name: sdrc_req_rcv

Overview:
- Responder end of the r2b/b2r request interface between the request generator and the bank controller.
- Accepts request chunks (r2b_req, answered with b2r_ack) into a small FIFO.
- Advertises b2r_arb_ok only when a full two-chunk (page-split) request is guaranteed to fit.
- Presents queued chunks to the downstream bank sequencer over a valid/ready interface.
- Checks start/last chunk framing.

Parameters:
- DEPTH, 4, FIFO entries; power of 2, minimum 2.
- ID_W, 4, request ID width (matches `SDR_REQ_ID_W).
- LEN_W, 12, chunk length width (matches `REQ_BW).

Ports:
- clk  in  1  clock
- reset_n  in  1  synchronous active-low reset
- r2b_req  in  1  chunk request, held until b2r_ack
- r2b_req_id  in  ID_W  request ID
- r2b_start  in  1  first chunk of app request
- r2b_last  in  1  last chunk of app request
- r2b_wrap  in  1  wrap mode
- r2b_write  in  1  1=write, 0=read
- r2b_ba  in  2  bank
- r2b_raddr  in  13  row
- r2b_caddr  in  13  column
- r2b_len  in  LEN_W  chunk length
- b2r_ack  out  1  chunk accepted this cycle
- b2r_arb_ok  out  1  at least two free entries
- q_valid  out  1  head entry valid
- q_ready  in  1  downstream consumes head
- q_req_id, q_start, q_last, q_wrap, q_write, q_ba, q_raddr, q_caddr, q_len  out  as inputs  head entry fields
- q_row_hit  out  1  head targets the open row of its bank (0 when feature off)
- row_close  in  4  per-bank pulse: bank precharged
- proto_err  out  1  sticky framing error
- count  out  $clog2(DEPTH)+1  occupancy

Behaviour:
- Reset (reset_n=0 at posedge):
  - wr/rd pointers and count = 0; q_valid = 0; proto_err = 0.
  - Framing tracker = "expect start".
  - Row tracker valid bits cleared.
  - Reset mid-operation discards all entries.
- Push:
  - push = r2b_req & (count < DEPTH).
  - b2r_ack = push, combinational, same cycle.
  - All r2b_* fields are sampled at the posedge where b2r_ack=1.
  - No acceptance when full; r2b_req simply waits.
- Pop: pop = q_valid & q_ready. Head fields are driven combinationally from the read-pointer entry.
- Latency: a chunk pushed at edge N is visible (q_valid=1) in cycle N+1. There is no empty-FIFO bypass.
- Simultaneous push and pop:
  - count unchanged; both pointers advance.
  - When full, a pop does not enable a same-cycle push (push uses the registered count).
- Pointers wrap modulo DEPTH. count ranges 0..DEPTH.
- b2r_arb_ok = (DEPTH - count) >= 2, combinational from registered count. The generator acks only in its idle state, so both chunks of a split request always fit.
- Framing check, on each push:
  - If the tracker expects start and r2b_start=0 → proto_err <= 1.
  - If the tracker expects continuation and r2b_start=1 → proto_err <= 1.
  - Tracker next state = r2b_last ? "expect start" : "expect continuation".
  - proto_err clears only on reset.
- Entry width = ID_W + 2 + 13 + 13 + LEN_W + 4.

Optional Feature:
- Macro: SDRC_ROW_HIT_EN.
- Defined:
  - Per-bank open-row register and valid bit.
  - On pop, row[q_ba] <= q_raddr and valid[q_ba] <= 1.
  - row_close[b] clears valid[b]; a close takes priority over a same-cycle pop update to the same bank.
  - q_row_hit = q_valid & valid[q_ba] & (row[q_ba] == q_raddr).
- Undefined: q_row_hit tied to 0; the tracker is not instantiated and row_close is ignored.

Decomposition:
- Shared package sdrc_pkg holds:
  - typedef r2b_entry_t (packed struct of all chunk fields);
  - framing enum {EXP_START, EXP_CONT};
  - constant BANKS = 4.
- One sub-module, sdrc_row_tracker (open-row table), instantiated only under SDRC_ROW_HIT_EN.

Test Plan:
1. Single chunk:
   - Stimulus: r2b_req with start=1, last=1, ba=2, raddr=0x15, caddr=0x10, len=8, q_ready=1.
   - Response: b2r_ack same cycle; q_valid next cycle with identical fields; count returns to 0; proto_err=0.
2. Page split:
   - Stimulus: two chunks (start=1,last=0,caddr=0xFC,len=4), then (start=0,last=1,caddr=0,len=4), q_ready=0.
   - Response: count=2; b2r_arb_ok falls once count=3 (DEPTH=4); chunks pop in order.
3. Full:
   - Stimulus: q_ready=0, four chunks pushed, fifth r2b_req held.
   - Response: b2r_ack=0 while count=4; one pop → fifth accepted the next cycle; count=4 again.
4. Simultaneous push and pop:
   - Stimulus: count=2, r2b_req and q_ready both high.
   - Response: count stays 2; pointers advance; data order preserved.
5. Framing errors:
   - Stimulus: push start=0 after reset.
   - Response: proto_err=1 next cycle and stays 1 until reset_n=0.
   - Stimulus: push start=1,last=0 followed by another start=1.
   - Response: proto_err=1.
6. Row hit (SDRC_ROW_HIT_EN):
   - Stimulus: pop ba=1 row=0x40, then head ba=1 row=0x40.
   - Response: q_row_hit=1.
   - Stimulus: pulse row_close[1].
   - Response: q_row_hit=0.
   - Without the macro, q_row_hit=0 throughout.
